// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer for the rv32i core
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   run                      level enable, sampled in IDLE and at the end of WRITEBACK
//   imem_ready, dmem_ready   memory handshake completions
//   is_load, is_store, rd_we decoded instruction class and rd write intent
//   pc_next_valid            next PC from program_counter is word aligned
//   imem_req, ir_load        instruction fetch request / instruction register latch
//   dmem_req, dmem_we        data request / write enable
//   update_pc, reg_write     commit strobes issued in WRITEBACK
//   trap, trap_cause         sticky trap flag and its cause
//   state                    current state encoding (debug)
//   retired_count            retired instruction count, wraps modulo 2^32
module pc_sequencer #(
    parameter int TIMEOUT    = 255,
    parameter int WAIT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        rd_we,
    input  logic        pc_next_valid,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        update_pc,
    output logic        reg_write,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO   = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO   = 2'b11;

    // Last tolerated count value; a not-ready cycle seen at this count is the
    // TIMEOUT-th consecutive one.
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT - 1);

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [1:0]             cause_q;
    logic [1:0]             cause_d;
    logic [WAIT_WIDTH-1:0]  wait_cnt;
    logic                   timeout_hit;
    logic                   retire;
    logic                   waiting;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    // A cycle spent stalled on the memory this state is talking to.
    assign waiting = ((cur_state == S_FETCH)  && !imem_ready) ||
                     ((cur_state == S_MEMORY) && !dmem_ready);

    always_comb begin
        nxt_state = cur_state;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        update_pc = 1'b0;
        reg_write = 1'b0;
        retire    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (run) nxt_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // Ready wins over a timeout landing in the same cycle.
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    nxt_state = S_DECODE;
                end else if (timeout_hit) begin
                    nxt_state = S_TRAP;
                    cause_d   = CAUSE_IMEM_TO;
                end
            end
            S_DECODE: begin
                nxt_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                nxt_state = (is_load || is_store) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    nxt_state = S_WRITEBACK;
                end else if (timeout_hit) begin
                    nxt_state = S_TRAP;
                    cause_d   = CAUSE_DMEM_TO;
                end
            end
            S_WRITEBACK: begin
                if (pc_next_valid) begin
                    update_pc = 1'b1;
                    reg_write = rd_we;
                    retire    = 1'b1;
                    nxt_state = run ? S_FETCH : S_IDLE;
                end else begin
                    nxt_state = S_TRAP;
                    cause_d   = CAUSE_MISALIGN;
                end
            end
            S_TRAP: begin
                nxt_state = S_TRAP;
            end
            default: begin
                // Corrupted state register: park in TRAP with no specific cause.
                nxt_state = S_TRAP;
                cause_d   = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state     <= S_IDLE;
            cause_q       <= CAUSE_NONE;
            wait_cnt      <= '0;
            retired_count <= 32'd0;
        end else begin
            cur_state <= nxt_state;
            cause_q   <= cause_d;
            if (retire) retired_count <= retired_count + 32'd1;
            // Any state change counts as entry, so FETCH and MEMORY always
            // start their wait window from zero.
            if (nxt_state != cur_state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign state      = cur_state;
    assign trap       = (cur_state == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a per-instruction timeline model
module tb_pc_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, imem_ready, dmem_ready, is_load, is_store, rd_we, pc_next_valid;
    logic        imem_req, ir_load, dmem_req, dmem_we, update_pc, reg_write, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] retired_count;

    pc_sequencer #(.TIMEOUT(TO), .WAIT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_load(is_load), .is_store(is_store), .rd_we(rd_we),
        .pc_next_valid(pc_next_valid),
        .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .update_pc(update_pc), .reg_write(reg_write),
        .trap(trap), .trap_cause(trap_cause),
        .state(state), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        imem_ready, dmem_ready, is_load, is_store, rd_we, pcv, run;
        logic [2:0]  st;
        logic        imem_req, ir_load, dmem_req, dmem_we, update_pc, reg_write, trap;
        logic [1:0]  cause;
        logic [31:0] retired;
    } cyc_t;

    cyc_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_retired;
    logic [1:0]  m_cause;
    bit          m_trapped;
    bit          m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One cycle in which no strobe may fire; inputs that do not matter are random.
    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.imem_ready = 1'($urandom); c.dmem_ready = 1'($urandom);
        c.is_load    = 1'($urandom); c.is_store   = 1'($urandom);
        c.rd_we      = 1'($urandom); c.pcv        = 1'($urandom);
        c.run        = 1'($urandom);
        c.st = st;
        c.imem_req = 0; c.ir_load = 0; c.dmem_req = 0; c.dmem_we = 0;
        c.update_pc = 0; c.reg_write = 0;
        c.trap = (st == 3'd6);
        c.cause = m_cause;
        c.retired = m_retired;
        return c;
    endfunction

    function automatic cyc_t ins(input logic [2:0] st, input bit ld, input bit sto,
                                 input bit rd, input bit pcv);
        cyc_t c;
        c = blank(st);
        c.is_load = ld; c.is_store = sto; c.rd_we = rd; c.pcv = pcv;
        return c;
    endfunction

    task automatic push_idle(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(3'd0); c.run = 1'b0; q.push_back(c);
        end
        c = blank(3'd0); c.run = 1'b1; q.push_back(c);
        m_idle = 0;
    endtask

    task automatic push_trap(input int n);
        for (int i = 0; i < n; i++) q.push_back(blank(3'd6));
    endtask

    // kind: 0 alu, 1 load, 2 store. f/d: not-ready cycles before ready; >= TO means never ready.
    task automatic push_instr(input int kind, input int f, input int d,
                              input bit rd, input bit pcv, input bit run_wb);
        cyc_t c;
        bit ld, sto;
        ld  = (kind == 1);
        sto = (kind == 2);
        for (int i = 0; i < f && i < TO; i++) begin
            c = ins(3'd1, ld, sto, rd, pcv); c.imem_ready = 0; c.imem_req = 1; q.push_back(c);
        end
        if (f >= TO) begin m_cause = 2'b10; m_trapped = 1; return; end
        c = ins(3'd1, ld, sto, rd, pcv); c.imem_ready = 1; c.imem_req = 1; c.ir_load = 1;
        q.push_back(c);
        q.push_back(ins(3'd2, ld, sto, rd, pcv));
        q.push_back(ins(3'd3, ld, sto, rd, pcv));
        if (ld || sto) begin
            for (int i = 0; i < d && i < TO; i++) begin
                c = ins(3'd4, ld, sto, rd, pcv); c.dmem_ready = 0;
                c.dmem_req = 1; c.dmem_we = sto; q.push_back(c);
            end
            if (d >= TO) begin m_cause = 2'b11; m_trapped = 1; return; end
            c = ins(3'd4, ld, sto, rd, pcv); c.dmem_ready = 1;
            c.dmem_req = 1; c.dmem_we = sto; q.push_back(c);
        end
        c = ins(3'd5, ld, sto, rd, pcv); c.run = run_wb;
        if (pcv) begin
            c.update_pc = 1; c.reg_write = rd;
            q.push_back(c);
            m_retired = m_retired + 32'd1;
            m_idle = !run_wb;
        end else begin
            q.push_back(c);
            m_cause = 2'b01; m_trapped = 1;
        end
    endtask

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
            is_load = c.is_load; is_store = c.is_store; rd_we = c.rd_we;
            pc_next_valid = c.pcv; run = c.run;
            #1;
            check("state",      32'(state),         32'(c.st));
            check("imem_req",   32'(imem_req),      32'(c.imem_req));
            check("ir_load",    32'(ir_load),       32'(c.ir_load));
            check("dmem_req",   32'(dmem_req),      32'(c.dmem_req));
            check("dmem_we",    32'(dmem_we),       32'(c.dmem_we));
            check("update_pc",  32'(update_pc),     32'(c.update_pc));
            check("reg_write",  32'(reg_write),     32'(c.reg_write));
            check("trap",       32'(trap),          32'(c.trap));
            check("trap_cause", 32'(trap_cause),    32'(c.cause));
            check("retired",    retired_count,      c.retired);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        is_load = 1'($urandom); is_store = 1'($urandom); rd_we = 1'($urandom);
        pc_next_valid = 1'($urandom); run = 1'($urandom);
        #1;
        check("rst_state",   32'(state),      32'd0);
        check("rst_trap",    32'(trap),       32'd0);
        check("rst_cause",   32'(trap_cause), 32'd0);
        check("rst_retired", retired_count,   32'd0);
        check("rst_strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, update_pc, reg_write}), 32'd0);
        repeat (2) @(negedge clk);
        run = 1'b0;
        rst = 1'b0;
        m_retired = 32'd0; m_cause = 2'b00; m_trapped = 0; m_idle = 1;
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 31));
        if (r < 16) return 0;
        if (r < 26) return int'($urandom_range(1, 5));
        if (r < 29) return TO - 1;
        return TO;
    endfunction

    initial begin
        int k;
        rst = 1'b1;
        run = 0; imem_ready = 0; dmem_ready = 0; is_load = 0; is_store = 0;
        rd_we = 0; pc_next_valid = 0;

        // ALU stream, slow load, then misaligned target held in TRAP.
        do_reset();
        push_idle(0);
        for (int i = 0; i < 3; i++) push_instr(0, 0, 0, 1, 1, 1);
        push_instr(1, 0, 3, 1, 1, 1);
        push_instr(0, 0, 0, 1, 0, 1);
        push_trap(20);
        play();

        // Fetch timeout boundary: ready on the 16th cycle passes, never ready traps.
        do_reset();
        push_idle(1);
        push_instr(0, TO - 1, 0, 1, 1, 0);
        push_idle(0);
        push_instr(2, 0, TO - 1, 0, 1, 1);
        push_instr(0, TO, 0, 1, 1, 1);
        push_trap(5);
        play();

        // Store that times out on the data side.
        do_reset();
        push_idle(0);
        push_instr(2, 1, TO, 0, 1, 1);
        push_trap(5);
        play();

        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int n = 0; n < 8 && !m_trapped; n++) begin
                if (m_idle) push_idle(int'($urandom_range(0, 2)));
                push_instr(int'($urandom_range(0, 2)), pick_lat(), pick_lat(),
                           1'($urandom), ($urandom_range(0, 15) != 0),
                           ($urandom_range(0, 3) != 0));
            end
            if (m_trapped) push_trap(int'($urandom_range(1, 20)));
            play();
        end

        // Reset asserted mid-MEMORY after one retirement.
        do_reset();
        run = 1; imem_ready = 1; dmem_ready = 0; is_load = 0; is_store = 0;
        rd_we = 1; pc_next_valid = 1;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (update_pc !== 1'b1 && k < 20);
        check("mr_retire_seen", 32'(update_pc), 32'd1);
        is_load = 1;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (state !== 3'd4 && k < 20);
        check("mr_in_memory", 32'(state),    32'd4);
        check("mr_dmem_req",  32'(dmem_req), 32'd1);
        check("mr_retired",   retired_count, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_dmem_req_async", 32'(dmem_req),  32'd0);
        check("mr_update_pc",      32'(update_pc), 32'd0);
        check("mr_reg_write",      32'(reg_write), 32'd0);
        check("mr_state",          32'(state),     32'd0);
        check("mr_retired_clr",    retired_count,  32'd0);
        @(negedge clk);
        run = 0;
        rst = 1'b0;
        @(negedge clk); #1;
        check("mr_resume_idle", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle control sequencer for the rv32i core. It steps each instruction through fetch, decode, execute, memory and writeback. It issues request handshakes to instruction and data memory and decides when the program counter commits `pc_next` via `update_pc`. It sits between the decoder and memories on one side and the `program_counter`/register-file strobes on the other. Misaligned jump targets and memory bus timeouts put it into a sticky trap state.

## Interface
- `TIMEOUT`, 255: consecutive not-ready cycles tolerated in FETCH/MEMORY before trapping; 0 disables timeout.
- `WAIT_WIDTH`, 8: width of the wait counter; must hold `TIMEOUT`.

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `run`  in  1  level enable; sampled in IDLE and at end of WRITEBACK
- `imem_ready`  in  1  instruction word valid this cycle
- `dmem_ready`  in  1  data access complete this cycle
- `is_load`  in  1  decoded instruction is a load
- `is_store`  in  1  decoded instruction is a store
- `rd_we`  in  1  decoded instruction writes rd
- `pc_next_valid`  in  1  from `program_counter`: next PC is word aligned
- `imem_req`  out  1  instruction fetch request
- `ir_load`  out  1  latch instruction register (1-cycle pulse)
- `dmem_req`  out  1  data memory request
- `dmem_we`  out  1  data write enable, qualified by `dmem_req`
- `update_pc`  out  1  commit `pc_next` (1-cycle pulse)
- `reg_write`  out  1  register file write strobe (1-cycle pulse)
- `trap`  out  1  sticky trap flag
- `trap_cause`  out  2  00 none, 01 misaligned target, 10 imem timeout, 11 dmem timeout
- `state`  out  3  current state encoding, debug
- `retired_count`  out  32  instructions retired, wraps modulo 2^32

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6. Encoding 7 is illegal and goes to TRAP with cause 00.
- IDLE:
  - All strobes 0.
  - `run`=1 goes to FETCH.
- FETCH:
  - `imem_req`=1.
  - If `imem_ready`=1: `ir_load`=1 in the same cycle, then go to DECODE.
  - Otherwise, on timeout: go to TRAP with cause 10.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: one cycle. If `is_load|is_store`, go to MEMORY; otherwise go to WRITEBACK.
- MEMORY:
  - `dmem_req`=1 and `dmem_we`=`is_store`, held stable until accepted.
  - If `dmem_ready`=1: go to WRITEBACK.
  - Otherwise, on timeout: go to TRAP with cause 11.
- WRITEBACK, when `pc_next_valid`=1:
  - `update_pc`=1 and `reg_write`=`rd_we`.
  - `retired_count` increments.
  - Next state is FETCH if `run`=1, else IDLE.
- WRITEBACK, when `pc_next_valid`=0:
  - `update_pc`=0, `reg_write`=0, and the count is unchanged.
  - Go to TRAP with cause 01.
- TRAP:
  - All strobes 0. `trap`=1 and `trap_cause` are held.
  - Only `rst` leaves this state.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle in which the state's ready input is 0.
  - Timeout fires when ready=0 and count==`TIMEOUT`-1, i.e. on the `TIMEOUT`th consecutive not-ready cycle.
  - Ready=1 always takes priority over timeout.
- Strobe decoding:
  - `imem_req`, `dmem_req`, `dmem_we`, `update_pc`, `reg_write` are combinational from state plus the listed inputs.
  - `ir_load` is combinational from state and `imem_ready`.
  - No strobe is ever asserted outside its state.

## Timing
- Reset:
  - `state`=IDLE, `trap`=0, `trap_cause`=00, `retired_count`=0, wait counter 0.
  - All strobes go 0 immediately on `rst` assertion, without waiting for a clock edge.
- Reset mid-operation: the in-flight access is abandoned, with no `update_pc` or `reg_write`. Release of `rst` resumes in IDLE.
- Latency with ready=1 on first request cycle:
  - Non-memory instruction: 4 cycles (F, D, E, W).
  - Load/store: 5 cycles.
  - Each not-ready cycle adds one cycle.
- `run`=0 never aborts an instruction. The current instruction completes and the sequencer parks in IDLE after WRITEBACK.
- `run`=1 continuously gives back-to-back instructions with no IDLE cycle.
- `retired_count` wraps from 0xFFFFFFFF to 0 without a flag.

## Test plan
- ALU stream:
  - Stimulus: `run`=1, `imem_ready`=1, `rd_we`=1, `pc_next_valid`=1.
  - Required: `update_pc` and `reg_write` pulse every 4th cycle; `retired_count`=3 after 12 cycles from first FETCH.
- Load with slow memory:
  - Stimulus: `is_load`=1, `dmem_ready` high on the 4th MEMORY cycle.
  - Required: `dmem_req` high 4 cycles with `dmem_we`=0; instruction takes 8 cycles; `reg_write` pulses once.
- Misaligned jump:
  - Stimulus: `pc_next_valid`=0 in WRITEBACK.
  - Required: `trap`=1, `trap_cause`=01, no `update_pc`, `retired_count` unchanged, `state`=6 held for 20 cycles.
- Fetch timeout, with `TIMEOUT`=16:
  - `imem_ready`=0 throughout gives TRAP with cause 10 after 16 FETCH cycles.
  - A repeat run with `imem_ready`=1 on the 16th cycle gives `ir_load` and DECODE, with no trap.
- Run/reset control:
  - `run` dropped in EXECUTE: WRITEBACK completes, then IDLE.
  - `rst` asserted in MEMORY: `dmem_req` goes 0 before the next edge, state=IDLE, `retired_count`=0.
